// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by WB (priority) and the MU,
// with a small MU result FIFO and a starvation guard that stalls WB.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 stall_wb,
  input  logic                 mu_valid,
  output logic                 mu_ready,
  input  logic [ADDR_W-1:0]    mu_rd,
  input  logic [DATA_W-1:0]    mu_data,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, FORCE} state_e;

  state_e              state_q, state_d;
  logic [ST_W-1:0]     starve_q, starve_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]   rdm_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   rdm_d [FIFO_DEPTH];
  logic [DATA_W-1:0]   dm_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]   dm_d  [FIFO_DEPTH];
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  logic empty, full, mu_live, wb_req;
  logic pop, push, bypass, wb_win;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign mu_ready = rst_n && !full;
  assign mu_live  = mu_valid && mu_ready && (mu_rd != '0);
  assign wb_req   = wb_valid && (wb_rd != '0);

  always_comb begin
    pop        = 1'b0;
    bypass     = 1'b0;
    wb_win     = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (state_q == FORCE) begin
      pop = 1'b1;
    end else if (wb_req) begin
      wb_win     = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end else if (!empty) begin
      pop = 1'b1;
    end else if (mu_live) begin
      bypass     = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = mu_rd;
      rf_wdata_d = mu_data;
    end
    if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = rdm_q[rptr_q];
      rf_wdata_d = dm_q[rptr_q];
    end
    push = mu_live && !bypass;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    vld_d   = vld_q;
    rdm_d   = rdm_q;
    dm_d    = dm_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PTR_W'(1);
    end
    // push and pop never share a slot: pop needs non-empty, push non-full
    if (push) begin
      vld_d[wptr_q] = 1'b1;
      rdm_d[wptr_q] = mu_rd;
      dm_d[wptr_q]  = mu_data;
      wptr_d        = wptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (state_q == FORCE) begin
      state_d  = NORMAL;
      starve_d = '0;
    end else begin
      if (pop || empty) starve_d = '0;
      else if (wb_win)  starve_d = starve_q + ST_W'(1);
      if (starve_d == ST_W'(STARVE_LIMIT)) state_d = FORCE;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (vld_q[i]) pend_mask[rdm_q[i]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rdm_q[i] <= '0;
        dm_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rdm_q      <= rdm_d;
      dm_q       <= dm_d;
    end
  end

  assign stall_wb   = (state_q == FORCE);
  assign fifo_count = count_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule
